// File: rtl/time_set_controller_pkg.sv
`default_nettype none
// =============================================================================
// tsc_pkg : shared encodings, field ranges and limits for time_set_controller
// Rev 1.0
// =============================================================================
package tsc_pkg;

  // State codes double as the S output code
  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_SET_TIME  = 2'b10,
    ST_SET_ALARM = 2'b11
  } state_e;

  localparam logic [1:0] S_RUN       = 2'b00;
  localparam logic [1:0] S_SET_TIME  = 2'b10;
  localparam logic [1:0] S_SET_ALARM = 2'b11;

  // Field codes double as the CW output code
  typedef enum logic [1:0] {
    FLD_NONE = 2'b00,
    FLD_MIN  = 2'b01,
    FLD_HR   = 2'b10,
    FLD_DAY  = 2'b11
  } field_e;

  localparam int DAY_HI = 14;
  localparam int DAY_LO = 12;
  localparam int HR_HI  = 11;
  localparam int HR_LO  = 7;
  localparam int MT_HI  = 6;
  localparam int MT_LO  = 4;
  localparam int MU_HI  = 3;
  localparam int MU_LO  = 0;

  localparam logic [7:0] MIN_MAX_BCD = 8'h59;
  localparam logic [4:0] HR_MAX      = 5'd23;
  localparam logic [2:0] DAY_MAX     = 3'd6;

  function automatic field_e next_field(input field_e f);
    case (f)
      FLD_MIN: return FLD_HR;
      FLD_HR:  return FLD_DAY;
      default: return FLD_MIN;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/time_set_controller_if.sv
`default_nettype none
// =============================================================================
// time_set_controller_if : button/time inputs and display/load outputs
// Rev 1.0
// =============================================================================
interface time_set_controller_if;
  logic        BMode;
  logic        BNext;
  logic        BUp;
  logic        BDown;
  logic [14:0] CT;
  logic [15:0] ST;
  logic [1:0]  S;
  logic [1:0]  CW;
  logic [1:0]  CW1;
  logic        Load;
  logic [14:0] LoadTime;

  modport slave (
    input  BMode, BNext, BUp, BDown, CT,
    output ST, S, CW, CW1, Load, LoadTime
  );

  modport master (
    output BMode, BNext, BUp, BDown, CT,
    input  ST, S, CW, CW1, Load, LoadTime
  );
endinterface
`default_nettype wire

// File: rtl/time_set_controller_stepper.sv
`default_nettype none
// =============================================================================
// time_field_stepper : steps one field of a packed time word with wrap, no carry
// Rev 1.0
// =============================================================================
module time_field_stepper
  import tsc_pkg::*;
(
  input  wire logic [14:0] word_i,
  input  field_e           field_i,
  input  wire logic        up_i,
  input  wire logic        down_i,
  output logic      [14:0] word_o
);

  logic [2:0] w_tens;
  logic [3:0] w_units;
  logic [4:0] w_hr;
  logic [2:0] w_day;

  assign w_tens  = word_i[MT_HI:MT_LO];
  assign w_units = word_i[MU_HI:MU_LO];
  assign w_hr    = word_i[HR_HI:HR_LO];
  assign w_day   = word_i[DAY_HI:DAY_LO];

  always_comb begin
    word_o = word_i;
    if (up_i ^ down_i) begin
      case (field_i)
        FLD_MIN: begin
          // Out-of-range minutes snap to the wrap value rather than stepping
          if (w_tens > 3'd5 || w_units > 4'd9) begin
            word_o[MT_HI:MU_LO] = up_i ? 7'h00 : 7'h59;
          end else if (up_i) begin
            if ({1'b0, w_tens, w_units} == MIN_MAX_BCD)
              word_o[MT_HI:MU_LO] = 7'h00;
            else if (w_units == 4'd9)
              word_o[MT_HI:MU_LO] = {w_tens + 3'd1, 4'd0};
            else
              word_o[MU_HI:MU_LO] = w_units + 4'd1;
          end else begin
            if (w_tens == 3'd0 && w_units == 4'd0)
              word_o[MT_HI:MU_LO] = 7'h59;
            else if (w_units == 4'd0)
              word_o[MT_HI:MU_LO] = {w_tens - 3'd1, 4'd9};
            else
              word_o[MU_HI:MU_LO] = w_units - 4'd1;
          end
        end
        FLD_HR: begin
          if (up_i)
            word_o[HR_HI:HR_LO] = (w_hr >= HR_MAX) ? 5'd0 : w_hr + 5'd1;
          else
            word_o[HR_HI:HR_LO] = (w_hr == 5'd0 || w_hr > HR_MAX) ? HR_MAX : w_hr - 5'd1;
        end
        FLD_DAY: begin
          if (up_i)
            word_o[DAY_HI:DAY_LO] = (w_day >= DAY_MAX) ? 3'd0 : w_day + 3'd1;
          else
            word_o[DAY_HI:DAY_LO] = (w_day == 3'd0 || w_day > DAY_MAX) ? DAY_MAX : w_day - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/time_set_controller.sv
`default_nettype none
// =============================================================================
// time_set_controller : front-panel mode FSM, edit buffer, alarm register, load
// Rev 1.0
// =============================================================================
module time_set_controller
  import tsc_pkg::*;
#(
  parameter int unsigned         TO_W           = 16,
  parameter logic [TO_W-1:0]     TIMEOUT_CYCLES = 16'd60000
) (
  input  wire logic              Clk,
  input  wire logic              Clr,
  time_set_controller_if.slave   bus
);

  state_e            state_q, state_d;
  field_e            fld_q, fld_d;
  logic [14:0]       buf_q, buf_d;
  logic [14:0]       alarm_q, alarm_d;
  logic              alm_en_q, alm_en_d;
  logic [TO_W-1:0]   idle_q, idle_d;
  logic              load_q, load_d;
  logic [14:0]       ltime_q, ltime_d;

  logic [14:0]       w_stepped;
  logic              w_any_btn;

  assign w_any_btn = bus.BMode | bus.BNext | bus.BUp | bus.BDown;

  time_field_stepper u_stepper (
    .word_i  (buf_q),
    .field_i (fld_q),
    .up_i    (bus.BUp),
    .down_i  (bus.BDown),
    .word_o  (w_stepped)
  );

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q  <= ST_RUN;
      fld_q    <= FLD_MIN;
      buf_q    <= '0;
      alarm_q  <= '0;
      alm_en_q <= 1'b0;
      idle_q   <= '0;
      load_q   <= 1'b0;
      ltime_q  <= '0;
    end else begin
      state_q  <= state_d;
      fld_q    <= fld_d;
      buf_q    <= buf_d;
      alarm_q  <= alarm_d;
      alm_en_q <= alm_en_d;
      idle_q   <= idle_d;
      load_q   <= load_d;
      ltime_q  <= ltime_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fld_d    = fld_q;
    buf_d    = buf_q;
    alarm_d  = alarm_q;
    alm_en_d = alm_en_q;
    idle_d   = '0;
    load_d   = 1'b0;
    ltime_d  = ltime_q;

    case (state_q)
      ST_RUN: begin
        if (bus.BMode) begin
          buf_d   = bus.CT;
          fld_d   = FLD_MIN;
          state_d = ST_SET_TIME;
        end else if (bus.BUp) begin
          alm_en_d = ~alm_en_q;
        end
      end
      ST_SET_TIME, ST_SET_ALARM: begin
        if (bus.BMode) begin
          if (state_q == ST_SET_TIME) begin
            load_d  = 1'b1;
            ltime_d = buf_q;
            buf_d   = alarm_q;
            fld_d   = FLD_MIN;
            state_d = ST_SET_ALARM;
          end else begin
            alarm_d = buf_q;
            state_d = ST_RUN;
          end
        end else if (bus.BNext) begin
          fld_d = next_field(fld_q);
        end else begin
          buf_d = w_stepped;
        end

        // A button in the expiry cycle wins and restarts the idle count
        if (!w_any_btn) begin
          if (idle_q == TIMEOUT_CYCLES - 1'b1)
            state_d = ST_RUN;
          else
            idle_d = idle_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign bus.S        = state_q;
  assign bus.CW       = (state_q == ST_RUN) ? FLD_NONE : fld_q;
  assign bus.CW1      = (state_q == ST_SET_ALARM) ? 2'b11 :
                        (state_q == ST_SET_TIME)  ? 2'b01 : 2'b00;
  assign bus.ST       = {alm_en_q, (state_q == ST_RUN) ? alarm_q : buf_q};
  assign bus.Load     = load_q;
  assign bus.LoadTime = ltime_q;

endmodule
`default_nettype wire

// File: tb/tb_time_set_controller.sv
`default_nettype none
// =============================================================================
// tb_time_set_controller : directed + random checks against a field-level model
// Rev 1.0
// =============================================================================
module tb_time_set_controller;

  localparam int T_OUT = 8;

  logic Clk = 1'b0;
  logic Clr = 1'b0;
  always #5 Clk = ~Clk;

  time_set_controller_if bus();

  time_set_controller #(.TO_W(16), .TIMEOUT_CYCLES(16'd8)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Model: mode 0 RUN, 1 SET_TIME, 2 SET_ALARM; field 0 min, 1 hour, 2 day
  int          m_mode = 0, m_fld = 0, m_idle = 0;
  int          b_day = 0, b_hr = 0, b_mt = 0, b_mu = 0;
  logic [14:0] m_alarm = '0;
  logic        m_alm = 1'b0;
  logic        m_load = 1'b0;
  logic [14:0] m_ltime = '0;

  function automatic logic [14:0] pack(input int d, input int h, input int t, input int u);
    logic [2:0] d3 = d[2:0];
    logic [4:0] h5 = h[4:0];
    logic [2:0] t3 = t[2:0];
    logic [3:0] u4 = u[3:0];
    return {d3, h5, t3, u4};
  endfunction

  task automatic unpack_to_buf(input logic [14:0] w);
    b_day = int'(w[14:12]);
    b_hr  = int'(w[11:7]);
    b_mt  = int'(w[6:4]);
    b_mu  = int'(w[3:0]);
  endtask

  task automatic model_reset();
    m_mode = 0; m_fld = 0; m_idle = 0;
    b_day = 0; b_hr = 0; b_mt = 0; b_mu = 0;
    m_alarm = '0; m_alm = 1'b0; m_load = 1'b0; m_ltime = '0;
  endtask

  task automatic model_step_field(input bit up);
    int v;
    case (m_fld)
      0: begin
        v = b_mt * 10 + b_mu;
        if (b_mt > 5 || b_mu > 9) v = up ? 0 : 59;
        else v = up ? (v + 1) % 60 : (v + 59) % 60;
        b_mt = v / 10; b_mu = v % 10;
      end
      1: if (up) b_hr = (b_hr >= 23) ? 0 : b_hr + 1;
         else    b_hr = (b_hr == 0 || b_hr > 23) ? 23 : b_hr - 1;
      default: if (up) b_day = (b_day >= 6) ? 0 : b_day + 1;
               else    b_day = (b_day == 0 || b_day > 6) ? 6 : b_day - 1;
    endcase
  endtask

  task automatic model_step(input bit bm, input bit bn, input bit bu, input bit bd,
                            input logic [14:0] ct);
    m_load = 1'b0;
    if (m_mode == 0) begin
      m_idle = 0;
      if (bm) begin unpack_to_buf(ct); m_fld = 0; m_mode = 1; end
      else if (bu) m_alm = ~m_alm;
    end else if (bm) begin
      m_idle = 0;
      if (m_mode == 1) begin
        m_load = 1'b1; m_ltime = pack(b_day, b_hr, b_mt, b_mu);
        unpack_to_buf(m_alarm); m_fld = 0; m_mode = 2;
      end else begin
        m_alarm = pack(b_day, b_hr, b_mt, b_mu); m_mode = 0;
      end
    end else if (bn) begin
      m_idle = 0; m_fld = (m_fld + 1) % 3;
    end else if (bu || bd) begin
      m_idle = 0;
      if (bu != bd) model_step_field(bu);
    end else if (m_idle == T_OUT - 1) begin
      m_idle = 0; m_mode = 0;
    end else begin
      m_idle = m_idle + 1;
    end
  endtask

  initial begin
    forever begin
      @(posedge Clk or negedge Clr);
      if (!Clr) model_reset();
      else model_step(bus.BMode, bus.BNext, bus.BUp, bus.BDown, bus.CT);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    forever begin
      logic [1:0]  e_s, e_cw, e_cw1;
      logic [15:0] e_st;
      @(negedge Clk);
      if (chk_en) begin
        e_s   = (m_mode == 0) ? 2'b00 : (m_mode == 1) ? 2'b10 : 2'b11;
        e_cw  = (m_mode == 0) ? 2'b00 : 2'(m_fld + 1);
        e_cw1 = (m_mode == 0) ? 2'b00 : (m_mode == 1) ? 2'b01 : 2'b11;
        e_st  = {m_alm, (m_mode == 0) ? m_alarm : pack(b_day, b_hr, b_mt, b_mu)};
        chk("model_ST", 32'(bus.ST), 32'(e_st));
        chk("model_S_CW_CW1", 32'({bus.S, bus.CW, bus.CW1}), 32'({e_s, e_cw, e_cw1}));
        chk("model_Load", 32'({bus.Load, bus.LoadTime}), 32'({m_load, m_ltime}));
      end
    end
  end

  // Inputs are applied 2 time units after a rising edge and held for one cycle
  task automatic press(input bit bm, input bit bn, input bit bu, input bit bd);
    bus.BMode = bm; bus.BNext = bn; bus.BUp = bu; bus.BDown = bd;
    @(posedge Clk); #2;
    bus.BMode = 1'b0; bus.BNext = 1'b0; bus.BUp = 1'b0; bus.BDown = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge Clk); #2; end
  endtask

  initial begin
    bus.BMode = 1'b0; bus.BNext = 1'b0; bus.BUp = 1'b0; bus.BDown = 1'b0;
    bus.CT = 15'h0000;
    repeat (2) @(posedge Clk);
    #2;
    chk_en = 1'b1;
    chk("reset_ST", 32'(bus.ST), 32'h0);
    chk("reset_S_Load", 32'({bus.S, bus.CW, bus.CW1, bus.Load}), 32'h0);
    Clr = 1'b1;
    idle_cycles(1);

    press(0, 0, 1, 0);
    @(negedge Clk); chk("alm_toggle_on", 32'({bus.ST, bus.S}), 32'({16'h8000, 2'b00}));
    #3; press(0, 0, 1, 0);
    @(negedge Clk); chk("alm_toggle_off", 32'(bus.ST), 32'h0);

    #3; bus.CT = 15'h26D9;
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    @(negedge Clk);
    chk("set_time_min_wrap", 32'({bus.S, bus.CW, bus.CW1, bus.ST[14:0]}),
        32'({2'b10, 2'b01, 2'b01, 15'h2680}));
    #3; press(1, 0, 0, 0);
    @(negedge Clk);
    chk("commit_load", 32'({bus.Load, bus.LoadTime, bus.S}), 32'({1'b1, 15'h2680, 2'b11}));
    @(negedge Clk); chk("load_single", 32'(bus.Load), 32'h0);

    // Alarm edit to day 1 06:30
    #3; press(0, 1, 0, 0);
    repeat (6) press(0, 0, 1, 0);
    press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    press(0, 1, 0, 0);
    repeat (30) press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    @(negedge Clk);
    chk("alarm_commit", 32'({bus.S, bus.Load, bus.ST}), 32'({2'b00, 1'b0, 16'h1330}));
    #3; press(0, 0, 1, 0);
    @(negedge Clk); chk("alarm_enable", 32'(bus.ST), 32'h9330);

    // Wraps: day 6 23:00
    #3; bus.CT = 15'h6B80;
    press(1, 0, 0, 0);
    press(0, 0, 0, 1);
    @(negedge Clk); chk("min_down_wrap", 32'(bus.ST[6:0]), 32'h59);
    #3; press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    @(negedge Clk); chk("hr_up_wrap", 32'({bus.CW, bus.ST[11:7]}), 32'({2'b10, 5'd0}));
    #3; press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    @(negedge Clk); chk("day_up_wrap", 32'({bus.CW, bus.ST[14:12]}), 32'({2'b11, 3'd0}));
    #3; press(1, 0, 1, 0);
    @(negedge Clk);
    chk("mode_beats_up", 32'({bus.Load, bus.LoadTime, bus.S}), 32'({1'b1, 15'h0059, 2'b11}));
    #3; press(0, 0, 1, 1);
    @(negedge Clk); chk("up_down_nop", 32'({bus.CW, bus.ST[14:0]}), 32'({2'b01, 15'h1330}));
    #3; press(1, 0, 0, 0);

    // Timeout from SET_TIME
    press(1, 0, 0, 0);
    for (int k = 0; k < T_OUT; k++) begin
      @(negedge Clk); chk("timeout_hold", 32'(bus.S), 32'h2);
    end
    @(negedge Clk);
    chk("timeout_exit", 32'({bus.S, bus.Load, bus.ST}), 32'({2'b00, 1'b0, 16'h9330}));

    // Asynchronous reset mid-edit
    #3; press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    Clr = 1'b0; #1;
    chk("clr_async", 32'({bus.ST, bus.S, bus.CW, bus.CW1, bus.Load}), 32'h0);
    @(posedge Clk); #2; Clr = 1'b1;

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      @(posedge Clk); #2;
      r = $urandom_range(0, 99);
      bus.BMode = 1'b0; bus.BNext = 1'b0; bus.BUp = 1'b0; bus.BDown = 1'b0;
      if (r < 8) bus.BMode = 1'b1;
      else if (r < 20) bus.BNext = 1'b1;
      else if (r < 40) bus.BUp = 1'b1;
      else if (r < 55) bus.BDown = 1'b1;
      else if (r < 60) {bus.BMode, bus.BNext, bus.BUp, bus.BDown} = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) bus.CT = 15'($urandom_range(0, 32767));
      if ($urandom_range(0, 149) == 0) begin
        bus.BMode = 1'b0; bus.BNext = 1'b0; bus.BUp = 1'b0; bus.BDown = 1'b0;
        idle_cycles(T_OUT + 3);
      end
      if ($urandom_range(0, 999) == 0) begin
        Clr = 1'b0;
        @(negedge Clk); #1; Clr = 1'b1;
      end
    end
    @(posedge Clk); #2;
    bus.BMode = 1'b0; bus.BNext = 1'b0; bus.BUp = 1'b0; bus.BDown = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
